uart_tx_serializer: RTL and testbench

- UART transmit serializer; the line-side end of the new_tx/tx_data/tx_busy byte interface driven by greeter-style producers.
- Accepts one byte per handshake and shifts it out as 8N1 (or 8N2) framing at a fixed baud derived from clk.
- Drives the FPGA serial TX pin.
- Provides a block input so a host-side flow-control signal (e.g. USB bridge not ready) can hold off new frames.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx_serializer.sv | 121 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//   uart_state_e        - transmitter FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   DATA_BITS           - payload bits per frame
//   CLK_PER_BIT_DEFAULT - default bit period in clk cycles (50 MHz / 500 kbaud)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS           = 8;
  localparam int CLK_PER_BIT_DEFAULT = 100;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter.
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   clear - hold counter at 0 (no tick while asserted)
//   tick  - one-cycle pulse in the last cycle of each CLK_PER_BIT-cycle period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CTR_SIZE = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CTR_SIZE-1:0] LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  logic [CTR_SIZE-1:0] ctr_q, ctr_d;

  // Counting 0..CLK_PER_BIT-1 and wrapping gives exactly CLK_PER_BIT cycles per period.
  assign tick = (ctr_q == LAST) && !clear;

  always_comb begin
    ctr_d = ctr_q + 1'b1;
    if (clear || tick) ctr_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctr_q <= '0;
    else      ctr_q <= ctr_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1/8N2 UART transmitter.
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   tx        - registered serial line, idle high
//   block     - host flow control; 1 prevents new frames from starting
//   busy      - 1 when new_data will not be accepted this cycle
//   data      - byte to transmit, sampled on accept
//   new_data  - single-cycle request strobe
//   dbg_state - current FSM state, for observation only
//
// Handshake: a byte is accepted on a rising edge where new_data=1 and busy=0
// (busy = state != IDLE | block). new_data while busy=1 is dropped; nothing
// is queued.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int STOP_BITS   = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        tx,
  input  logic        block,
  output logic        busy,
  input  logic [7:0]  data,
  input  logic        new_data,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        tick;
  logic        accept;

  // Timer is held cleared in IDLE so every frame starts on a fresh period.
  uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  assign busy      = (state_q != IDLE) | block;
  assign accept    = new_data & ~busy;
  assign tx        = tx_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = data;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        // idx_q doubles as the stop-bit counter for the 2-stop-bit case.
        if (tick) begin
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is decoded from next-state so the registered pin changes on the same
  // edge as the state, keeping the pin glitch-free without a cycle of lag.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       tx;
  logic       block;
  logic       busy;
  logic [7:0] data;
  logic       new_data;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx        (tx),
    .block     (block),
    .busy      (busy),
    .data      (data),
    .new_data  (new_data),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int hi_run = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All sampling and driving happens on the falling edge.
  task automatic cyc();
    @(negedge clk);
    if (tx === 1'b1) hi_run++;
    else             hi_run = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with busy=0; returns at the first falling edge
  // of the frame (tx low).
  task automatic send(input logic [7:0] b);
    data     = b;
    new_data = 1'b1;
    exp_q.push_back(b);
    cyc();
    new_data = 1'b0;
  endtask

  // Checks the 40 frame samples starting at the current falling edge.
  // kind 1: pulse new_data with 0x55 at sample 'at' (must be dropped)
  // kind 2: raise block at sample 'at'
  task automatic check_frame(input string tag, input int at, input int kind);
    logic [7:0] b;
    logic [7:0] rx;
    logic       exp_tx;
    int         bit_n;
    int         err;
    b   = exp_q.pop_front();
    rx  = 8'h00;
    err = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) cyc();
      if (i == at + 1) new_data = 1'b0;
      if (i == at && kind == 1) begin data = 8'h55; new_data = 1'b1; end
      if (i == at && kind == 2) block = 1'b1;
      bit_n = i / CPB;
      if (bit_n == 0)      exp_tx = 1'b0;
      else if (bit_n == 9) exp_tx = 1'b1;
      else                 exp_tx = b[bit_n-1];
      if (bit_n >= 1 && bit_n <= 8 && (i % CPB) == 2) rx[bit_n-1] = tx;
      if (tx !== exp_tx || busy !== 1'b1) err++;
    end
    check({tag, "_bits"}, err, 0);
    check({tag, "_byte"}, rx, b);
    cyc();
    check({tag, "_done_tx"}, tx, 1'b1);
    check({tag, "_done_busy"}, busy, block);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    string hello;
    int    err;
    hello    = "Hello World!\r\n";
    rst      = 1'b0;
    block    = 1'b0;
    data     = 8'h00;
    new_data = 1'b0;

    // Reset
    repeat (3) cyc();
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_state", dbg_state, 2'd0);
    rst = 1'b1;
    err = 0;
    repeat (50) begin
      cyc();
      if (tx !== 1'b1 || busy !== 1'b0) err++;
    end
    check("idle_after_reset", err, 0);

    // Single byte 'h'
    send(8'h68);
    check("h_start_latency", tx, 1'b0);
    check_frame("single_h", -5, 0);

    // Drop while busy
    send(8'h48);
    check_frame("drop", 10, 1);
    err = 0;
    repeat (20) begin
      cyc();
      if (tx !== 1'b1 || busy !== 1'b0) err++;
    end
    check("drop_line_idle", err, 0);

    // Block in IDLE wins over new_data
    block = 1'b1;
    #1 check("block_busy_comb", busy, 1'b1);
    data = 8'h41; new_data = 1'b1;
    cyc();
    new_data = 1'b0;
    err = 0;
    repeat (45) begin
      cyc();
      if (tx !== 1'b1 || busy !== 1'b1 || dbg_state !== 2'd0) err++;
    end
    check("block_no_start", err, 0);
    block = 1'b0;
    #1 check("unblock_busy", busy, 1'b0);
    cyc();

    // Block raised mid-frame
    send(8'h42);
    check_frame("block_mid", 20, 2);
    err = 0;
    repeat (10) begin
      cyc();
      if (tx !== 1'b1 || busy !== 1'b1) err++;
    end
    check("block_hold", err, 0);
    block = 1'b0;
    #1 check("block_release", busy, 1'b0);
    cyc();

    // Back-to-back greeter
    for (int k = 0; k < hello.len(); k++) begin
      send(hello[k]);
      check($sformatf("gap_%0d", k), hi_run, 0);
      check_frame($sformatf("hello_%0d", k), -5, 0);
      if (k > 0) ; // gap verified below from the high-run before the next start
      if (k < hello.len() - 1) begin
        // Stop period (4) plus the idle accept cycle (1) precede the next start.
        check($sformatf("gap_len_%0d", k), hi_run >= 5 ? 32'd5 : hi_run, 5);
      end
    end

    // Reset mid-frame during data bit 3 of 0xA5
    cyc();
    send(8'hA5);
    void'(exp_q.pop_front());
    repeat (4 * CPB + 1) cyc();
    check("a5_before_reset", tx, 1'b0);
    rst = 1'b0;
    #1 check("async_reset_tx", tx, 1'b1);
    check("async_reset_state", dbg_state, 2'd0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    check("post_reset_busy", busy, 1'b0);
    send(8'h0F);
    check("0f_start", tx, 1'b0);
    check_frame("after_reset", -5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck simulation.
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
